// File: rtl/dual_issue_top.sv
// Minimal in-order dual-issue RV32I core: two-wide fetch from an internal store,
// two parallel ALUs and a shared 32x32 register file; dependent pairs issue singly.
`timescale 1ns/1ps

module dual_issue_top #(
  parameter int unsigned DEPTH     = 16,
  parameter string       INIT_FILE = "",
  parameter int unsigned LED_REG   = 3
) (
  input  logic       clk,
  input  logic       rst_pin,
  output logic [7:0] led
);
  localparam int unsigned PC_W    = $clog2(DEPTH + 2);
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP  = 7'h33;
  localparam logic [6:0]  OPC_IMM = 7'h13;
  localparam logic [6:0]  OPC_LUI = 7'h37;

  logic [PC_W-1:0] pc;
  logic [31:0]     instruction0, instruction1;
  logic [31:0]     ALU_result1, ALU_result2;
  logic            freeze1, freeze2;
  logic            datapath_1_enable, datapath_2_enable;
  logic [31:0]     a1, r2_1, b1, a2, r2_2, b2;
  logic [4:0]      rd0, rd1;
  logic            wr0, raw, waw;
  logic            we0, we1;

  function automatic logic [31:0] default_word(input int unsigned idx);
    case (idx)
      0:       return 32'h0050_0093;
      1:       return 32'h0030_0113;
      2:       return 32'h0020_81B3;
      3:       return 32'h4020_8233;
      default: return NOP;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_IMM) || (opc == OPC_LUI);
  endfunction

  function automatic logic reads_rs1(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_IMM);
  endfunction

  function automatic logic [31:0] alu(input logic [6:0]  opc,
                                      input logic [2:0]  f3,
                                      input logic        alt,
                                      input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [31:0] upper);
    logic [31:0] res;
    res = '0;
    if (opc == OPC_LUI) begin
      res = upper;
    end else if (opc == OPC_OP || opc == OPC_IMM) begin
      case (f3)
        3'd0:    res = (opc == OPC_OP && alt) ? a - b : a + b;
        3'd1:    res = a << b[4:0];
        3'd2:    res = {31'd0, $signed(a) < $signed(b)};
        3'd3:    res = {31'd0, a < b};
        3'd4:    res = a ^ b;
        3'd5:    res = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6:    res = a | b;
        default: res = a & b;
      endcase
    end
    return res;
  endfunction

  // Instruction store; contents survive reset, the slot-1 fetch pads with nop past the end.
  if (1) begin : cache_inst
    logic [31:0] ins [0:DEPTH-1];

    initial begin
      for (int unsigned i = 0; i < DEPTH; i++) ins[i] = default_word(i);
    end

    always_comb begin
      instruction0 = NOP;
      instruction1 = NOP;
      if (32'(pc) < DEPTH)      instruction0 = ins[AW'(pc)];
      if (32'(pc) + 1 < DEPTH)  instruction1 = ins[AW'(pc + PC_W'(1))];
    end
  end

  // Register file: two combinational read pairs, two write ports, x0 hardwired to zero.
  if (1) begin : reg_file_inst
    logic [31:0] registers [0:31];

    always_ff @(posedge clk or negedge rst_pin) begin
      if (!rst_pin) begin
        for (int i = 0; i < 32; i++) registers[i] <= '0;
      end else begin
        if (we0 && rd0 != 5'd0) registers[rd0] <= ALU_result1;
        if (we1 && rd1 != 5'd0) registers[rd1] <= ALU_result2;
      end
    end

    assign a1   = (instruction0[19:15] == 5'd0) ? '0 : registers[instruction0[19:15]];
    assign r2_1 = (instruction0[24:20] == 5'd0) ? '0 : registers[instruction0[24:20]];
    assign a2   = (instruction1[19:15] == 5'd0) ? '0 : registers[instruction1[19:15]];
    assign r2_2 = (instruction1[24:20] == 5'd0) ? '0 : registers[instruction1[24:20]];
    assign led  = registers[5'(LED_REG)][7:0];
  end

  // Execute both slots from the same pre-issue register state; no intra-pair forwarding.
  always_comb begin
    b1 = (instruction0[6:0] == OPC_OP) ? r2_1 : {{20{instruction0[31]}}, instruction0[31:20]};
    b2 = (instruction1[6:0] == OPC_OP) ? r2_2 : {{20{instruction1[31]}}, instruction1[31:20]};
    ALU_result1 = alu(instruction0[6:0], instruction0[14:12], instruction0[30], a1, b1,
                      {instruction0[31:12], 12'h000});
    ALU_result2 = alu(instruction1[6:0], instruction1[14:12], instruction1[30], a2, b2,
                      {instruction1[31:12], 12'h000});
  end

  // Pair hazard detection and halt.
  always_comb begin
    rd0     = instruction0[11:7];
    rd1     = instruction1[11:7];
    wr0     = writes_rd(instruction0[6:0]) && (rd0 != 5'd0);
    raw     = (reads_rs1(instruction1[6:0]) && (instruction1[19:15] == rd0)) ||
              ((instruction1[6:0] == OPC_OP) && (instruction1[24:20] == rd0));
    waw     = writes_rd(instruction1[6:0]) && (rd1 == rd0);
    freeze1 = (32'(pc) >= DEPTH);
    freeze2 = freeze1 || (wr0 && (raw || waw));
  end

  assign datapath_1_enable = !freeze1;
  assign datapath_2_enable = !freeze2;
  assign we0 = datapath_1_enable && writes_rd(instruction0[6:0]);
  assign we1 = datapath_2_enable && writes_rd(instruction1[6:0]);

  always_ff @(posedge clk or negedge rst_pin) begin
    if (!rst_pin) begin
      pc <= '0;
    end else if (datapath_2_enable) begin
      pc <= pc + PC_W'(2);
    end else if (datapath_1_enable) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: tb/tb_dual_issue_top.sv
// Bench for dual_issue_top: directed scenarios plus random programs compared
// cycle by cycle against an instruction-level reference model.
`timescale 1ns/1ps

module tb_dual_issue_top;
  localparam int DEPTH = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic       clk;
  logic       rst_pin;
  logic [7:0] led;

  int checks;
  int passed;

  logic [31:0] m_ins  [DEPTH];
  logic [31:0] m_regs [32];
  int          m_pc;
  logic [31:0] prog_q [$];

  dual_issue_top #(.DEPTH(DEPTH), .INIT_FILE(""), .LED_REG(3)) dut (
    .clk     (clk),
    .rst_pin (rst_pin),
    .led     (led)
  );

  initial begin
    clk = 1'b0;
    forever #1 clk = ~clk;
  end

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd);
    return {20'(imm20), 5'(rd), 7'h37};
  endfunction

  // Instruction semantics: result, whether it writes, and its destination.
  function automatic void m_exec(input logic [31:0] ins, output bit wr, output logic [4:0] rd,
                                 output logic [31:0] res);
    logic [6:0]  opc;
    logic [31:0] x, y;
    int          sh;
    bit          r_type;
    opc    = ins[6:0];
    rd     = ins[11:7];
    wr     = 1'b0;
    res    = '0;
    r_type = (opc == 7'h33);
    x      = m_regs[ins[19:15]];
    y      = r_type ? m_regs[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
    sh     = int'(y % 32);
    if (opc == 7'h37) begin
      wr  = 1'b1;
      res = ins & 32'hFFFF_F000;
    end else if (r_type || opc == 7'h13) begin
      wr = 1'b1;
      case (ins[14:12])
        3'd0:    res = (r_type && ins[30]) ? 32'(longint'(x) - longint'(y)) : 32'(longint'(x) + longint'(y));
        3'd1:    res = 32'(longint'(x) << sh);
        3'd2:    res = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
        3'd3:    res = (x < y) ? 32'd1 : 32'd0;
        3'd4:    res = x ^ y;
        3'd5:    res = ins[30] ? 32'(int'(x) >>> sh) : 32'(longint'(x) >> sh);
        3'd6:    res = x | y;
        default: res = x & y;
      endcase
    end
  endfunction

  function automatic bit m_depends(input logic [31:0] i0, input logic [31:0] i1);
    logic [4:0] srcs [$];
    logic [4:0] d0;
    d0 = i0[11:7];
    if (!(i0[6:0] inside {7'h33, 7'h13, 7'h37}) || d0 == 5'd0) return 1'b0;
    if (i1[6:0] inside {7'h33, 7'h13}) srcs.push_back(i1[19:15]);
    if (i1[6:0] == 7'h33) srcs.push_back(i1[24:20]);
    if ((i1[6:0] inside {7'h33, 7'h13, 7'h37}) && i1[11:7] == d0) return 1'b1;
    foreach (srcs[k]) if (srcs[k] == d0) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model one clock; reports the expected split and both slot results.
  function automatic void m_step(output bit split, output logic [31:0] r0, output logic [31:0] r1);
    logic [31:0] i0, i1;
    bit          w0, w1;
    logic [4:0]  d0, d1;
    r0 = '0;
    r1 = '0;
    if (m_pc >= DEPTH) begin
      split = 1'b1;
      return;
    end
    i0 = m_ins[m_pc];
    i1 = (m_pc + 1 < DEPTH) ? m_ins[m_pc + 1] : NOP;
    m_exec(i0, w0, d0, r0);
    m_exec(i1, w1, d1, r1);
    split = m_depends(i0, i1);
    if (w0 && d0 != 5'd0) m_regs[d0] = r0;
    if (!split && w1 && d1 != 5'd0) m_regs[d1] = r1;
    m_pc += split ? 1 : 2;
  endfunction

  function automatic logic [31:0] rand_instr();
    int          k, rd, rs1, rs2, f3, imm;
    logic [31:0] raw;
    logic [6:0]  bad_opc [4];
    bad_opc = '{7'h03, 7'h23, 7'h63, 7'h6F};
    k   = $urandom_range(0, 9);
    rd  = $urandom_range(0, 7);
    rs1 = $urandom_range(0, 7);
    rs2 = $urandom_range(0, 7);
    f3  = $urandom_range(0, 7);
    if (k <= 3) begin
      return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0, rs2, rs1, f3, rd);
    end else if (k <= 7) begin
      imm = $urandom_range(0, 4095);
      if (f3 == 1) imm = $urandom_range(0, 31);
      if (f3 == 5) imm = $urandom_range(0, 31) + ($urandom_range(0, 1) == 1 ? 1024 : 0);
      return enc_i(imm, rs1, f3, rd);
    end else if (k == 8) begin
      return enc_u($urandom_range(0, 1048575), rd);
    end
    raw = $urandom();
    return {raw[31:7], bad_opc[$urandom_range(0, 3)]};
  endfunction

  // Holds reset, loads prog_q into the store and the model, releases on a falling edge.
  task automatic load_and_reset();
    @(negedge clk);
    rst_pin = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_ins[i] = (i < prog_q.size()) ? prog_q[i] : NOP;
      dut.cache_inst.ins[i] = m_ins[i];
    end
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = 0;
    repeat (2) @(negedge clk);
    rst_pin = 1'b1;
  endtask

  task automatic model_cycle(input string tag);
    bit          sp, live;
    logic [31:0] e0, e1;
    int          bad;
    live = (m_pc < DEPTH);
    m_step(sp, e0, e1);
    checks++;
    if (dut.freeze2 !== sp) $display("FAIL %s freeze2: got %b want %b", tag, dut.freeze2, sp);
    else passed++;
    if (live) begin
      checks++;
      if (dut.ALU_result1 !== e0) $display("FAIL %s ALU_result1: got %h want %h", tag, dut.ALU_result1, e0);
      else passed++;
      checks++;
      if (dut.ALU_result2 !== e1) $display("FAIL %s ALU_result2: got %h want %h", tag, dut.ALU_result2, e1);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (int'(dut.pc) !== m_pc) $display("FAIL %s pc: got %0d want %0d", tag, dut.pc, m_pc);
    else passed++;
    bad = -1;
    for (int r = 31; r >= 0; r--) if (dut.reg_file_inst.registers[r] !== m_regs[r]) bad = r;
    checks++;
    if (bad >= 0) $display("FAIL %s regs: x%0d got %h want %h", tag, bad,
                           dut.reg_file_inst.registers[bad], m_regs[bad]);
    else passed++;
  endtask

  task automatic test_reset();
    int nz;
    #20;
    @(negedge clk);
    checks++;
    if (dut.pc !== '0) $display("FAIL reset pc: got %0d want 0", dut.pc); else passed++;
    nz = 0;
    for (int r = 0; r < 32; r++) if (dut.reg_file_inst.registers[r] !== 32'd0) nz++;
    checks++;
    if (nz != 0) $display("FAIL reset regs: %0d nonzero want 0", nz); else passed++;
    checks++;
    if (led !== 8'h00) $display("FAIL reset led: got %h want 00", led); else passed++;
    checks++;
    if (dut.instruction0 !== 32'h0050_0093) $display("FAIL reset instruction0: got %h want 00500093", dut.instruction0);
    else passed++;
    checks++;
    if (dut.ALU_result1 !== 32'd5) $display("FAIL reset ALU_result1: got %h want 00000005", dut.ALU_result1);
    else passed++;
  endtask

  task automatic test_default_program();
    rst_pin = 1'b1;
    checks++;
    if (dut.freeze2 !== 1'b0) $display("FAIL default freeze2_c1: got %b want 0", dut.freeze2); else passed++;
    @(negedge clk);
    checks++;
    if (dut.reg_file_inst.registers[1] !== 32'd5) $display("FAIL default x1: got %h want 5", dut.reg_file_inst.registers[1]);
    else passed++;
    checks++;
    if (dut.reg_file_inst.registers[2] !== 32'd3) $display("FAIL default x2: got %h want 3", dut.reg_file_inst.registers[2]);
    else passed++;
    @(negedge clk);
    checks++;
    if (dut.reg_file_inst.registers[3] !== 32'd8) $display("FAIL default x3: got %h want 8", dut.reg_file_inst.registers[3]);
    else passed++;
    @(negedge clk);
    checks++;
    if (dut.reg_file_inst.registers[4] !== 32'd2) $display("FAIL default x4: got %h want 2", dut.reg_file_inst.registers[4]);
    else passed++;
    checks++;
    if (led !== 8'h08) $display("FAIL default led: got %h want 08", led); else passed++;
  endtask

  task automatic test_dual_independent();
    prog_q = {};
    prog_q.push_back(enc_i(-1, 0, 0, 5));
    prog_q.push_back(enc_i(7, 0, 0, 6));
    load_and_reset();
    checks++;
    if (dut.freeze2 !== 1'b0) $display("FAIL dual freeze2: got %b want 0", dut.freeze2); else passed++;
    @(negedge clk);
    checks++;
    if (dut.reg_file_inst.registers[5] !== 32'hFFFF_FFFF) $display("FAIL dual x5: got %h want ffffffff", dut.reg_file_inst.registers[5]);
    else passed++;
    checks++;
    if (dut.reg_file_inst.registers[6] !== 32'd7) $display("FAIL dual x6: got %h want 7", dut.reg_file_inst.registers[6]);
    else passed++;
    checks++;
    if (dut.pc !== 5'd2) $display("FAIL dual pc: got %0d want 2", dut.pc); else passed++;
  endtask

  task automatic test_waw();
    prog_q = {};
    prog_q.push_back(enc_i(1, 0, 0, 7));
    prog_q.push_back(enc_i(2, 0, 0, 7));
    load_and_reset();
    checks++;
    if (dut.freeze2 !== 1'b1) $display("FAIL waw freeze2: got %b want 1", dut.freeze2); else passed++;
    @(negedge clk);
    checks++;
    if (dut.reg_file_inst.registers[7] !== 32'd1) $display("FAIL waw x7_first: got %h want 1", dut.reg_file_inst.registers[7]);
    else passed++;
    checks++;
    if (dut.pc !== 5'd1) $display("FAIL waw pc: got %0d want 1", dut.pc); else passed++;
    @(negedge clk);
    checks++;
    if (dut.reg_file_inst.registers[7] !== 32'd2) $display("FAIL waw x7_second: got %h want 2", dut.reg_file_inst.registers[7]);
    else passed++;
  endtask

  task automatic test_x0_wrap();
    prog_q = {};
    prog_q.push_back(enc_i(9, 0, 0, 0));
    prog_q.push_back(enc_u(32'h80000, 8));
    prog_q.push_back(enc_r(0, 8, 8, 0, 9));
    prog_q.push_back(enc_i(1024 + 31, 8, 5, 10));
    prog_q.push_back(enc_i(31, 8, 5, 11));
    load_and_reset();
    for (int c = 0; c < DEPTH / 2 + 2; c++) model_cycle("wrap");
    checks++;
    if (dut.reg_file_inst.registers[0] !== 32'd0) $display("FAIL wrap x0: got %h want 0", dut.reg_file_inst.registers[0]);
    else passed++;
    checks++;
    if (dut.reg_file_inst.registers[8] !== 32'h8000_0000) $display("FAIL wrap x8: got %h want 80000000", dut.reg_file_inst.registers[8]);
    else passed++;
    checks++;
    if (dut.reg_file_inst.registers[9] !== 32'd0) $display("FAIL wrap x9: got %h want 0", dut.reg_file_inst.registers[9]);
    else passed++;
    checks++;
    if (dut.reg_file_inst.registers[10] !== 32'hFFFF_FFFF) $display("FAIL wrap x10_sra: got %h want ffffffff", dut.reg_file_inst.registers[10]);
    else passed++;
    checks++;
    if (dut.reg_file_inst.registers[11] !== 32'd1) $display("FAIL wrap x11_srl: got %h want 1", dut.reg_file_inst.registers[11]);
    else passed++;
  endtask

  task automatic test_halt();
    int bad;
    checks++;
    if (dut.freeze1 !== 1'b1 || dut.freeze2 !== 1'b1) $display("FAIL halt freezes: got %b%b want 11", dut.freeze1, dut.freeze2);
    else passed++;
    checks++;
    if (dut.datapath_1_enable !== 1'b0 || dut.datapath_2_enable !== 1'b0)
      $display("FAIL halt enables: got %b%b want 00", dut.datapath_1_enable, dut.datapath_2_enable);
    else passed++;
    repeat (20) @(negedge clk);
    bad = -1;
    for (int r = 31; r >= 0; r--) if (dut.reg_file_inst.registers[r] !== m_regs[r]) bad = r;
    checks++;
    if (bad >= 0) $display("FAIL halt regs: x%0d got %h want %h", bad, dut.reg_file_inst.registers[bad], m_regs[bad]);
    else passed++;
    checks++;
    if (int'(dut.pc) !== m_pc) $display("FAIL halt pc: got %0d want %0d", dut.pc, m_pc); else passed++;
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      prog_q = {};
      for (int i = 0; i < DEPTH; i++) prog_q.push_back(rand_instr());
      load_and_reset();
      for (int c = 0; c < DEPTH + 3; c++) model_cycle($sformatf("rand%0d_c%0d", p, c));
    end
  endtask

  task automatic test_reset_midrun();
    int nz;
    prog_q = {};
    for (int i = 0; i < DEPTH; i++) prog_q.push_back(rand_instr());
    prog_q[0] = enc_i(-3, 0, 0, 3);
    load_and_reset();
    for (int c = 0; c < 3; c++) model_cycle("midrun_pre");
    #0.3 rst_pin = 1'b0;
    #0.2;
    nz = 0;
    for (int r = 0; r < 32; r++) if (dut.reg_file_inst.registers[r] !== 32'd0) nz++;
    checks++;
    if (nz != 0) $display("FAIL midrun regs: %0d nonzero want 0", nz); else passed++;
    checks++;
    if (dut.pc !== '0) $display("FAIL midrun pc: got %0d want 0", dut.pc); else passed++;
    checks++;
    if (led !== 8'h00) $display("FAIL midrun led: got %h want 00", led); else passed++;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = 0;
    @(negedge clk);
    rst_pin = 1'b1;
    for (int c = 0; c < DEPTH + 3; c++) model_cycle("midrun_post");
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    rst_pin = 1'b1;
    #0.2 rst_pin = 1'b0;
    test_reset();
    test_default_program();
    test_dual_independent();
    test_waw();
    test_x0_wrap();
    test_halt();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
